// File: rtl/nv_nvdla_csb2apb.sv
// CSB slave to APB master bridge, one outstanding transfer; zero-wait read responds 3 cycles after accept.
// Backpressure: csb2nvdla_ready is high only in IDLE, so pready wait states and timeouts stall new requests.
module nv_nvdla_csb2apb #(
  parameter logic [31:0] PADDR_BASE  = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        csb2nvdla_valid,
  output logic        csb2nvdla_ready,
  input  logic [15:0] csb2nvdla_addr,
  input  logic [31:0] csb2nvdla_wdat,
  input  logic        csb2nvdla_write,
  input  logic        csb2nvdla_nposted,
  output logic        nvdla2csb_valid,
  output logic [31:0] nvdla2csb_data,
  output logic        nvdla2csb_wr_complete,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        apb_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic          r_write;
  logic          r_nposted;
  logic          r_psel;
  logic          r_penable;
  logic [31:0]   r_paddr;
  logic [31:0]   r_pwdata;
  logic [31:0]   r_rdata;
  logic          r_rsp_vld;
  logic          r_wr_cmp;
  logic          r_apb_err;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_done;
  logic          w_err;
  logic          w_timeout;
  logic [CW-1:0] w_cnt_inc;

  assign csb2nvdla_ready = (r_state == IDLE) & ~prst;
  assign w_accept        = csb2nvdla_valid & csb2nvdla_ready;
  assign w_cnt_inc       = r_cnt + 1'b1;
  // The wait that would bring the counter up to the limit is the last one.
  assign w_timeout       = (TIMEOUT_CYC != 0) && !pready && (w_cnt_inc == TO_LIMIT);

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          w_done = 1'b1;
          w_err  = pslverr;
        end else if (w_timeout) begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end
        if (w_done) begin
          w_state_nxt = (r_write && !r_nposted) ? IDLE : RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_write   <= 1'b0;
      r_nposted <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= 32'h0;
      r_pwdata  <= 32'h0;
      r_rdata   <= 32'h0;
      r_rsp_vld <= 1'b0;
      r_wr_cmp  <= 1'b0;
      r_apb_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_rsp_vld <= w_done & ~r_write;
      r_wr_cmp  <= w_done & r_write & r_nposted;
      r_apb_err <= w_done & w_err;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write   <= csb2nvdla_write;
            r_nposted <= csb2nvdla_nposted;
            r_paddr   <= {PADDR_BASE[31:18], csb2nvdla_addr, 2'b00};
            r_pwdata  <= csb2nvdla_wdat;
            r_psel    <= 1'b1;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        ACCESS: begin
          if (w_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (!r_write) begin
              r_rdata <= w_err ? 32'h0 : prdata;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign psel                  = r_psel;
  assign penable               = r_penable;
  assign pwrite                = r_write;
  assign paddr                 = r_paddr;
  assign pwdata                = r_pwdata;
  assign nvdla2csb_valid       = r_rsp_vld;
  assign nvdla2csb_wr_complete = r_wr_cmp;
  assign nvdla2csb_data        = r_rdata;
  assign apb_err               = r_apb_err;

endmodule

// File: tb/tb_nv_nvdla_csb2apb.sv
// Directed bench for nv_nvdla_csb2apb with a 4-cycle timeout; expected values are hand-computed.
module tb_nv_nvdla_csb2apb;

  logic        pclk = 1'b0;
  logic        prst;
  logic        csb2nvdla_valid;
  logic        csb2nvdla_ready;
  logic [15:0] csb2nvdla_addr;
  logic [31:0] csb2nvdla_wdat;
  logic        csb2nvdla_write;
  logic        csb2nvdla_nposted;
  logic        nvdla2csb_valid;
  logic [31:0] nvdla2csb_data;
  logic        nvdla2csb_wr_complete;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        apb_err;

  int checks = 0;
  int errors = 0;

  nv_nvdla_csb2apb #(
    .PADDR_BASE (32'h0000_0000),
    .TIMEOUT_CYC(4)
  ) dut (
    .pclk                 (pclk),
    .prst                 (prst),
    .csb2nvdla_valid      (csb2nvdla_valid),
    .csb2nvdla_ready      (csb2nvdla_ready),
    .csb2nvdla_addr       (csb2nvdla_addr),
    .csb2nvdla_wdat       (csb2nvdla_wdat),
    .csb2nvdla_write      (csb2nvdla_write),
    .csb2nvdla_nposted    (csb2nvdla_nposted),
    .nvdla2csb_valid      (nvdla2csb_valid),
    .nvdla2csb_data       (nvdla2csb_data),
    .nvdla2csb_wr_complete(nvdla2csb_wr_complete),
    .psel                 (psel),
    .penable              (penable),
    .pwrite               (pwrite),
    .paddr                (paddr),
    .pwdata               (pwdata),
    .prdata               (prdata),
    .pready               (pready),
    .pslverr              (pslverr),
    .apb_err              (apb_err)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response-side snapshot: {valid, wr_complete, apb_err, psel, penable, ready}
  function automatic logic [31:0] ctl();
    return {26'h0, nvdla2csb_valid, nvdla2csb_wr_complete, apb_err, psel, penable, csb2nvdla_ready};
  endfunction

  initial begin
    prst = 1'b1;
    csb2nvdla_valid = 1'b0;
    csb2nvdla_addr = 16'h0;
    csb2nvdla_wdat = 32'h0;
    csb2nvdla_write = 1'b0;
    csb2nvdla_nposted = 1'b0;
    prdata = 32'h0;
    pready = 1'b0;
    pslverr = 1'b0;
    tick();
    tick();
    chk("rst_ctl", ctl(), 32'h00);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pwrite", {31'h0, pwrite}, 32'h0);
    chk("rst_data", nvdla2csb_data, 32'h0);
    prst = 1'b0;
    #1;
    chk("rst_rel_ready", ctl(), 32'h01);

    // Zero-wait read at 0x1234; pready/pslverr driven in SETUP must be ignored.
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = 16'h1234;
    tick();
    csb2nvdla_valid = 1'b0;
    pready = 1'b1;
    pslverr = 1'b1;
    chk("rd_setup_ctl", ctl(), 32'h04);
    chk("rd_paddr", paddr, 32'h0000_48D0);
    chk("rd_pwrite", {31'h0, pwrite}, 32'h0);
    tick();
    pslverr = 1'b0;
    prdata = 32'hCAFE_F00D;
    chk("rd_access_ctl", ctl(), 32'h06);
    tick();
    pready = 1'b0;
    chk("rd_resp_ctl", ctl(), 32'h20);
    chk("rd_resp_data", nvdla2csb_data, 32'hCAFE_F00D);
    tick();
    chk("rd_t4_ctl", ctl(), 32'h01);
    chk("rd_hold_data", nvdla2csb_data, 32'hCAFE_F00D);

    // Posted write with three wait states.
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = 16'h0010;
    csb2nvdla_wdat = 32'hA5A5_5A5A;
    csb2nvdla_write = 1'b1;
    csb2nvdla_nposted = 1'b0;
    tick();
    csb2nvdla_valid = 1'b0;
    csb2nvdla_wdat = 32'h0;
    chk("pw_setup_ctl", ctl(), 32'h04);
    chk("pw_paddr", paddr, 32'h0000_0040);
    chk("pw_pwrite", {31'h0, pwrite}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      pready = (i == 3);
      chk($sformatf("pw_access%0d_ctl", i), ctl(), 32'h06);
      chk($sformatf("pw_access%0d_pwdata", i), pwdata, 32'hA5A5_5A5A);
    end
    tick();
    pready = 1'b0;
    chk("pw_done_ctl", ctl(), 32'h01);
    tick();
    chk("pw_idle_ctl", ctl(), 32'h01);

    // Non-posted write with slave error.
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = 16'h0020;
    csb2nvdla_wdat = 32'h1357_9BDF;
    csb2nvdla_nposted = 1'b1;
    tick();
    csb2nvdla_valid = 1'b0;
    chk("npw_setup_ctl", ctl(), 32'h04);
    chk("npw_pwdata", pwdata, 32'h1357_9BDF);
    tick();
    pready = 1'b1;
    pslverr = 1'b1;
    chk("npw_access_ctl", ctl(), 32'h06);
    tick();
    pready = 1'b0;
    pslverr = 1'b0;
    chk("npw_resp_ctl", ctl(), 32'h18);
    chk("npw_data_held", nvdla2csb_data, 32'hCAFE_F00D);
    tick();
    chk("npw_idle_ctl", ctl(), 32'h01);

    // Read timing out after four ACCESS cycles.
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = 16'h0003;
    csb2nvdla_write = 1'b0;
    csb2nvdla_nposted = 1'b0;
    prdata = 32'hDEAD_BEEF;
    tick();
    csb2nvdla_valid = 1'b0;
    chk("to_setup_ctl", ctl(), 32'h04);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to_access%0d_ctl", i), ctl(), 32'h06);
    end
    tick();
    chk("to_resp_ctl", ctl(), 32'h28);
    chk("to_resp_data", nvdla2csb_data, 32'h0);
    tick();
    chk("to_idle_ctl", ctl(), 32'h01);

    // Back-to-back reads with valid held; address change outside IDLE must not be captured.
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = 16'h0001;
    tick();
    csb2nvdla_addr = 16'h0002;
    chk("bb1_setup_ctl", ctl(), 32'h04);
    chk("bb1_paddr", paddr, 32'h0000_0004);
    tick();
    pready = 1'b1;
    prdata = 32'h1111_1111;
    chk("bb1_access_paddr", paddr, 32'h0000_0004);
    tick();
    pready = 1'b0;
    chk("bb1_resp_ctl", ctl(), 32'h20);
    chk("bb1_resp_data", nvdla2csb_data, 32'h1111_1111);
    tick();
    chk("bb_gap_ctl", ctl(), 32'h01);
    tick();
    csb2nvdla_valid = 1'b0;
    chk("bb2_setup_ctl", ctl(), 32'h04);
    chk("bb2_paddr", paddr, 32'h0000_0008);
    tick();
    pready = 1'b1;
    prdata = 32'h2222_2222;
    tick();
    pready = 1'b0;
    chk("bb2_resp_ctl", ctl(), 32'h20);
    chk("bb2_resp_data", nvdla2csb_data, 32'h2222_2222);
    tick();
    chk("bb2_idle_ctl", ctl(), 32'h01);
    tick();
    chk("bb_no_dup_ctl", ctl(), 32'h01);

    // Reset in the middle of ACCESS with pready pending.
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = 16'h0040;
    tick();
    csb2nvdla_valid = 1'b0;
    tick();
    chk("ra_access_ctl", ctl(), 32'h06);
    prst = 1'b1;
    #1;
    chk("ra_ready_in_rst", ctl(), 32'h06);
    tick();
    chk("ra_rst_ctl", ctl(), 32'h00);
    chk("ra_rst_data", nvdla2csb_data, 32'h0);
    prst = 1'b0;
    #1;
    chk("ra_post_ready", ctl(), 32'h01);
    tick();
    chk("ra_no_resp", ctl(), 32'h01);
    tick();
    chk("ra_still_idle", ctl(), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
